// File: rtl/piso_16x1_pkg.sv
// piso_16x1_pkg: FSM state encoding and the width helper shared by the serializer and its interface.
package piso_16x1_pkg;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/piso_16x1_if.sv
// piso_16x1_if: load/word side and serial output side of the serializer.
interface piso_16x1_if #(parameter int WIDTH = 16);
    localparam int LEN_W = piso_16x1_pkg::clog2(WIDTH);
    logic             ce;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [LEN_W-1:0] len;
    logic             so;
    logic             so_vld;
    logic             busy;
    logic             done;
    logic             ovr;
    modport master (output ce, load, d, len, input so, so_vld, busy, done, ovr);
    modport slave  (input ce, load, d, len, output so, so_vld, busy, done, ovr);
endinterface

// File: rtl/piso_16x1.sv
// piso_16x1: loads a word and shifts out LEN+1 bits on CE edges, framed by so_vld, ending with a done pulse.
module piso_16x1
    import piso_16x1_pkg::*;
#(
    parameter int   WIDTH     = 16,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_LVL  = 1'b0
) (
    input logic        clk,
    input logic        rstn,
    piso_16x1_if.slave bus
);
    localparam int LEN_W = clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             so_q, so_d;
    logic             so_vld_q, so_vld_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ovr_q, ovr_d;

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        so_d     = so_q;
        so_vld_d = so_vld_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ovr_d    = bus.ce && bus.load && (state_q == S_SHIFT || state_q == S_DONE);
        case (state_q)
            S_IDLE: if (bus.ce && bus.load) begin
                sr_d     = bus.d;
                cnt_d    = (32'(bus.len) > WIDTH - 1) ? LEN_W'(WIDTH - 1) : bus.len;
                so_d     = MSB_FIRST ? bus.d[WIDTH-1] : bus.d[0];
                so_vld_d = 1'b1;
                busy_d   = 1'b1;
                state_d  = S_SHIFT;
            end
            S_SHIFT: if (bus.ce) begin
                // sr keeps the current bit at the output end; the next bit sits one place behind it
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    sr_d  = MSB_FIRST ? sr_q << 1 : sr_q >> 1;
                    so_d  = MSB_FIRST ? sr_q[WIDTH-2] : sr_q[1];
                end else begin
                    so_d     = IDLE_LVL;
                    so_vld_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                sr_d     = '0;
                cnt_d    = '0;
                so_d     = IDLE_LVL;
                so_vld_d = 1'b0;
                busy_d   = 1'b0;
                ovr_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            sr_q     <= '0;
            cnt_q    <= '0;
            so_q     <= IDLE_LVL;
            so_vld_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            so_q     <= so_d;
            so_vld_q <= so_vld_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
        end
    end

    assign bus.so     = so_q;
    assign bus.so_vld = so_vld_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.ovr    = ovr_q;
endmodule

// File: tb/tb_piso_16x1.sv
// tb_piso_16x1: drives MSB-first and LSB-first serializers with shared stimulus against a bit-sequence model.
module tb_piso_16x1;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    piso_16x1_if #(.WIDTH(16)) ifm ();
    piso_16x1_if #(.WIDTH(16)) ifl ();

    assign ifl.ce   = ifm.ce;
    assign ifl.load = ifm.load;
    assign ifl.d    = ifm.d;
    assign ifl.len  = ifm.len;

    piso_16x1 #(.WIDTH(16), .MSB_FIRST(1'b1), .IDLE_LVL(1'b0)) u_msb (.clk(clk), .rstn(rstn), .bus(ifm));
    piso_16x1 #(.WIDTH(16), .MSB_FIRST(1'b0), .IDLE_LVL(1'b0)) u_lsb (.clk(clk), .rstn(rstn), .bus(ifl));

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", nm, got, exp);
        else n_pass++;
    endtask

    // Transmission order as a list: element i is the i-th bit to appear on SO.
    function automatic logic [15:0] order(input logic [15:0] d, input bit msb);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = msb ? d[15-i] : d[i];
        return r;
    endfunction

    logic [15:0] m_seq [2];
    int          m_pos [2];
    int          m_n   [2];
    logic        m_so [2], m_vld [2], m_busy [2], m_done [2], m_ovr [2];
    bit          armed = 1'b0;

    initial for (int k = 0; k < 2; k++) begin
        m_seq[k] = '0; m_pos[k] = 0; m_n[k] = 0;
        m_so[k] = 1'b0; m_vld[k] = 1'b0; m_busy[k] = 1'b0; m_done[k] = 1'b0; m_ovr[k] = 1'b0;
    end

    always @(posedge clk) begin
        armed <= 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (!rstn) begin
                m_so[k] <= 1'b0; m_vld[k] <= 1'b0; m_busy[k] <= 1'b0; m_done[k] <= 1'b0; m_ovr[k] <= 1'b0;
            end else begin
                m_ovr[k] <= ifm.ce && ifm.load && m_busy[k];
                if (m_done[k]) begin
                    m_done[k] <= 1'b0;
                    m_busy[k] <= 1'b0;
                end else if (m_busy[k]) begin
                    if (ifm.ce) begin
                        if (m_pos[k] < m_n[k]) begin
                            m_so[k]  <= m_seq[k][m_pos[k]];
                            m_pos[k] <= m_pos[k] + 1;
                        end else begin
                            m_so[k] <= 1'b0; m_vld[k] <= 1'b0; m_done[k] <= 1'b1;
                        end
                    end
                end else if (ifm.ce && ifm.load) begin
                    m_seq[k]  <= order(ifm.d, k == 0);
                    m_n[k]    <= int'(ifm.len) + 1;
                    m_pos[k]  <= 1;
                    m_so[k]   <= (k == 0) ? ifm.d[15] : ifm.d[0];
                    m_vld[k]  <= 1'b1;
                    m_busy[k] <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) if (armed) begin
        check("msb_cycle", {ifm.so, ifm.so_vld, ifm.busy, ifm.done, ifm.ovr},
              {m_so[0], m_vld[0], m_busy[0], m_done[0], m_ovr[0]});
        check("lsb_cycle", {ifl.so, ifl.so_vld, ifl.busy, ifl.done, ifl.ovr},
              {m_so[1], m_vld[1], m_busy[1], m_done[1], m_ovr[1]});
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start(input logic [15:0] d, input logic [3:0] len);
        ifm.d = d; ifm.len = len; ifm.ce = 1'b1; ifm.load = 1'b1;
        tick(1);
        ifm.load = 1'b0;
    endtask

    initial begin
        logic [15:0] cap;
        int vcnt;
        ifm.ce = 1'b0; ifm.load = 1'b0; ifm.d = '0; ifm.len = '0;
        tick(2);
        check("rst_so", ifm.so, 0);
        check("rst_vld", ifm.so_vld, 0);
        check("rst_busy", ifm.busy, 0);
        check("rst_done", ifm.done, 0);
        check("rst_ovr", ifm.ovr, 0);
        rstn = 1'b1;
        tick(1);

        start(16'hA5C3, 4'd15);
        cap = '0; vcnt = 0;
        for (int i = 0; i < 16; i++) begin
            cap = {cap[14:0], ifm.so}; vcnt += int'(ifm.so_vld);
            tick(1);
        end
        check("a5c3_bits", cap, 16'hA5C3);
        check("a5c3_vld_cnt", 16'(vcnt), 16);
        check("a5c3_done", ifm.done, 1);
        check("a5c3_busy_in_done", ifm.busy, 1);
        tick(1);
        check("a5c3_done_end", ifm.done, 0);
        check("a5c3_busy_end", ifm.busy, 0);

        start(16'h0013, 4'd4);
        cap = '0;
        for (int i = 0; i < 5; i++) begin
            cap = {cap[14:0], ifl.so};
            tick(1);
        end
        check("lsb5_bits", cap, 16'b11001);
        check("lsb5_done", ifl.done, 1);
        tick(1);
        start(16'h0013, 4'd0);
        check("len0_bit", ifl.so, 1);
        check("len0_vld", ifl.so_vld, 1);
        tick(1);
        check("len0_done", ifl.done, 1);
        check("len0_vld_off", ifl.so_vld, 0);
        tick(1);

        start(16'hA5C3, 4'd15);
        cap = '0;
        for (int i = 0; i < 16; i++) begin
            cap = {cap[14:0], ifm.so};
            ifm.ce = 1'b0; tick(2);
            ifm.ce = 1'b1; tick(1);
        end
        check("ce_bits", cap, 16'hA5C3);
        check("ce_done", ifm.done, 1);
        ifm.ce = 1'b0;
        tick(1);
        check("ce_done_1clk", ifm.done, 0);
        check("ce_busy_end", ifm.busy, 0);
        ifm.ce = 1'b1;
        tick(1);

        start(16'hF00F, 4'd7);
        tick(2);
        ifm.d = 16'h0000; ifm.len = 4'd2; ifm.load = 1'b1;
        tick(1);
        ifm.load = 1'b0;
        check("ovr_shift", ifm.ovr, 1);
        tick(1);
        check("ovr_clear", ifm.ovr, 0);
        for (int i = 0; i < 20 && !ifm.done; i++) tick(1);
        check("ovr_wait_done", ifm.done, 1);
        ifm.d = 16'hBEEF; ifm.len = 4'd3; ifm.load = 1'b1;
        tick(1);
        check("ovr_done_cycle", ifm.ovr, 1);
        check("ovr_idle", ifm.busy, 0);
        tick(1);
        ifm.load = 1'b0;
        check("ovr_accept", ifm.busy, 1);
        check("ovr_accept_vld", ifm.so_vld, 1);
        for (int i = 0; i < 20 && ifm.busy; i++) tick(1);
        check("ovr_end", ifm.busy, 0);
        tick(1);

        start(16'hA5C3, 4'd15);
        tick(5);
        rstn = 1'b0;
        tick(1);
        check("rst_mid_so", ifm.so, 0);
        check("rst_mid_vld", ifm.so_vld, 0);
        check("rst_mid_busy", ifm.busy, 0);
        rstn = 1'b1;
        tick(2);
        check("rst_mid_done", ifm.done, 0);
        start(16'h1234, 4'd15);
        cap = '0;
        for (int i = 0; i < 16; i++) begin
            cap = {cap[14:0], ifm.so};
            tick(1);
        end
        check("clean_bits", cap, 16'h1234);
        check("clean_done", ifm.done, 1);
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
